// File: rtl/usi_slave_csr.sv
// USI bus slave with pCsrNum R/W CSRs, one RO status word and a drop counter.
// Define USI_CSR_DROPCNT_EN to include the dropped-command counter at index pCsrNum+1.
module usi_slave_csr #(
   parameter logic [7:0]  pBusAdrs = 8'h01,
   parameter int          pCsrNum  = 8,
   parameter logic [31:0] pCsrInit = 32'h0000_0000
) (
   input  logic                     iUsiClk,
   input  logic                     iUsiRst,
   input  logic [31:0]              iSUsiWd,
   input  logic [31:0]              iSUsiAdrs,
   input  logic                     iSUsiWCke,
   output logic [31:0]              oSUsiRd,
   output logic                     oSUsiVd,
   output logic [32*pCsrNum-1:0]    oCsrQ,
   output logic [pCsrNum-1:0]       oCsrWe,
   input  logic [31:0]              iCsrStatus
);

   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

   localparam logic [15:0] StsIdx = 16'(pCsrNum);

   state_e      state_q, state_d;
   logic [31:0] wd_q, wd_d;
   logic [15:0] idx_q, idx_d;
   logic [31:0] rd_q, rd_d;
   logic [31:0] csr_q [pCsrNum];
   logic [31:0] csr_d [pCsrNum];
   logic [pCsrNum-1:0] we;
   logic [31:0] rdata;
   logic [1:0]  cmd;
   logic        hit;
   logic        unused;

   assign unused = ^iSUsiAdrs[29:24];
   assign cmd    = iSUsiAdrs[31:30];
   // A valid, addressed read or write; accepted in IDLE, dropped otherwise
   assign hit    = iSUsiWCke && (iSUsiAdrs[23:16] == pBusAdrs)
                   && (cmd == 2'd1 || cmd == 2'd2);

`ifdef USI_CSR_DROPCNT_EN
   logic [7:0] drop_q, drop_d;
   logic       clr, drop;

   assign clr  = (state_q == WR) && (idx_q == StsIdx + 16'd1);
   assign drop = hit && (state_q != IDLE);

   always_comb begin
      drop_d = drop_q;
      if (clr)
         drop_d = 8'h00;
      else if (drop && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge iUsiClk) begin
      if (iUsiRst)
         drop_q <= 8'h00;
      else
         drop_q <= drop_d;
   end
`endif

   always_comb begin
      rdata = 32'h0;
      for (int n = 0; n < pCsrNum; n++)
         if (idx_q == 16'(n))
            rdata = csr_q[n];
      if (idx_q == StsIdx)
         rdata = iCsrStatus;
`ifdef USI_CSR_DROPCNT_EN
      if (idx_q == StsIdx + 16'd1)
         rdata = {24'h0, drop_q};
`endif
   end

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      idx_d   = idx_q;
      rd_d    = rd_q;
      csr_d   = csr_q;
      we      = '0;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               wd_d    = iSUsiWd;
               idx_d   = iSUsiAdrs[15:0];
               state_d = (cmd == 2'd1) ? WR : RD;
            end
         end
         WR: begin
            state_d = DONE;
            for (int n = 0; n < pCsrNum; n++) begin
               if (idx_q == 16'(n)) begin
                  csr_d[n] = wd_q;
                  we[n]    = 1'b1;
               end
            end
         end
         RD: begin
            state_d = DONE;
            rd_d    = rdata;
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iUsiClk) begin
      if (iUsiRst) begin
         state_q <= IDLE;
         wd_q    <= 32'h0;
         idx_q   <= 16'h0;
         rd_q    <= 32'h0;
         for (int n = 0; n < pCsrNum; n++)
            csr_q[n] <= pCsrInit;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         idx_q   <= idx_d;
         rd_q    <= rd_d;
         for (int n = 0; n < pCsrNum; n++)
            csr_q[n] <= csr_d[n];
      end
   end

   // The acceptance cycle already counts as busy, so Vd drops with it
   assign oSUsiVd = iUsiRst || (state_q == IDLE && !hit);
   assign oSUsiRd = iUsiRst ? 32'h0 : rd_q;
   assign oCsrWe  = iUsiRst ? '0 : we;

   for (genvar g = 0; g < pCsrNum; g++) begin : g_q
      assign oCsrQ[32*g +: 32] = csr_q[g];
   end

endmodule

// File: tb/tb_usi_slave_csr.sv
// Directed self-checking bench for usi_slave_csr (default parameters).
// Drop-counter scenarios follow USI_CSR_DROPCNT_EN.
module tb_usi_slave_csr;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  wd = '0;
   logic [31:0]  adrs = '0;
   logic         wcke = 1'b0;
   logic [31:0]  rd;
   logic         vd;
   logic [255:0] csrq;
   logic [7:0]   csrwe;
   logic [31:0]  sts = '0;

   int errors = 0;
   int checks = 0;
   int we_seen = 0;

   always #5 clk = ~clk;

   always @(negedge clk)
      if (csrwe !== 8'h00) we_seen++;

   usi_slave_csr dut (
      .iUsiClk   (clk),
      .iUsiRst   (rst),
      .iSUsiWd   (wd),
      .iSUsiAdrs (adrs),
      .iSUsiWCke (wcke),
      .oSUsiRd   (rd),
      .oSUsiVd   (vd),
      .oCsrQ     (csrq),
      .oCsrWe    (csrwe),
      .iCsrStatus(sts)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic [7:0] a,
                        input logic [15:0] i, input logic [31:0] d);
      adrs = {c, 6'h0, a, i};
      wd   = d;
      wcke = 1'b1;
   endtask

   task automatic idle_bus();
      wcke = 1'b0;
      adrs = '0;
   endtask

   task automatic do_cmd(input logic [1:0] c, input logic [15:0] i,
                         input logic [31:0] d);
      tick();
      drive(c, 8'h01, i, d);
      tick();
      idle_bus();
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_bus();
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (csrq !== '0) begin
         errors++;
         $display("FAIL reset_csr got %h want 0", csrq);
      end
      checks++;
      if (vd !== 1'b1) begin
         errors++;
         $display("FAIL reset_vd got %b want 1", vd);
      end
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd got %h want 0", rd);
      end
      rst = 1'b0;
   endtask

   task automatic test_write();
      tick();
      drive(2'd1, 8'h01, 16'd3, 32'hA5A5_0003);
      @(negedge clk);
      checks++;
      if (vd !== 1'b0 || csrwe !== 8'h00) begin
         errors++;
         $display("FAIL wr_accept vd=%b we=%h want 0/00", vd, csrwe);
      end
      tick();
      idle_bus();
      wd = 32'hFFFF_FFFF;
      adrs = {2'd1, 6'h0, 8'h01, 16'd5};
      @(negedge clk);
      checks++;
      if (csrwe !== 8'b0000_1000 || vd !== 1'b0) begin
         errors++;
         $display("FAIL wr_pulse we=%b vd=%b want 00001000/0", csrwe, vd);
      end
      tick();
      @(negedge clk);
      checks++;
      if (csrwe !== 8'h00 || vd !== 1'b0) begin
         errors++;
         $display("FAIL wr_done we=%b vd=%b want 0/0", csrwe, vd);
      end
      checks++;
      if (csrq[96 +: 32] !== 32'hA5A5_0003) begin
         errors++;
         $display("FAIL wr_csr3 got %h want a5a50003", csrq[96 +: 32]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (vd !== 1'b1 || csrq[160 +: 32] !== 32'h0) begin
         errors++;
         $display("FAIL wr_idle vd=%b csr5=%h want 1/0", vd, csrq[160 +: 32]);
      end
   endtask

   task automatic test_read();
      tick();
      drive(2'd2, 8'h01, 16'd3, 32'h0);
      tick();
      idle_bus();
      tick();
      @(negedge clk);
      checks++;
      if (rd !== 32'hA5A5_0003) begin
         errors++;
         $display("FAIL rd_done got %h want a5a50003", rd);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         @(negedge clk);
         checks++;
         if (rd !== 32'hA5A5_0003 || vd !== 1'b1) begin
            errors++;
            $display("FAIL rd_hold[%0d] rd=%h vd=%b want a5a50003/1", k, rd, vd);
         end
      end
   endtask

   task automatic test_status();
      int we0;
      logic [255:0] q0;
      sts = 32'hDEAD_BEEF;
      do_cmd(2'd2, 16'd8, 32'h0);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL rd_status got %h want deadbeef", rd);
      end
      do_cmd(2'd2, 16'd12, 32'h0);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rd_oor got %h want 0", rd);
      end
      we0 = we_seen;
      q0  = csrq;
      do_cmd(2'd1, 16'd8, 32'h1234_5678);
      do_cmd(2'd1, 16'd12, 32'h1111_2222);
      checks++;
      if (we_seen != we0 || csrq !== q0) begin
         errors++;
         $display("FAIL wr_ro we_pulses=%0d want %0d csr=%h", we_seen, we0, csrq);
      end
      do_cmd(2'd2, 16'd8, 32'h0);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL rd_status2 got %h want deadbeef", rd);
      end
   endtask

   task automatic test_mismatch();
      tick();
      drive(2'd1, 8'h01, 16'd7, 32'h0000_0007);
      tick();
      drive(2'd1, 8'h02, 16'd1, 32'hFFFF_FFFF);
      tick();
      drive(2'd3, 8'h01, 16'd1, 32'hFFFF_FFFF);
      tick();
      @(negedge clk);
      checks++;
      if (vd !== 1'b1) begin
         errors++;
         $display("FAIL mm_cmd3 vd got %b want 1", vd);
      end
      tick();
      drive(2'd1, 8'h02, 16'd1, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (vd !== 1'b1) begin
         errors++;
         $display("FAIL mm_adr vd got %b want 1", vd);
      end
      tick();
      drive(2'd0, 8'h01, 16'd1, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (vd !== 1'b1) begin
         errors++;
         $display("FAIL mm_cmd0 vd got %b want 1", vd);
      end
      tick();
      idle_bus();
      @(negedge clk);
      checks++;
      if (csrq[32 +: 32] !== 32'h0 || csrq[224 +: 32] !== 32'h7) begin
         errors++;
         $display("FAIL mm_csr csr1=%h csr7=%h want 0/7", csrq[32 +: 32], csrq[224 +: 32]);
      end
      do_cmd(2'd2, 16'd9, 32'h0);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL mm_dropcnt got %h want 0", rd);
      end
   endtask

   task automatic test_back_to_back();
      int we0;
      tick();
      drive(2'd1, 8'h01, 16'd0, 32'h0000_0001);
      tick();
      drive(2'd2, 8'h01, 16'd2, 32'h0);
      tick();
      drive(2'd1, 8'h01, 16'd4, 32'h4444_4444);
      tick();
      idle_bus();
      tick();
      checks++;
      if (csrq[128 +: 32] !== 32'h0 || csrq[0 +: 32] !== 32'h1) begin
         errors++;
         $display("FAIL b2b_csr csr4=%h csr0=%h want 0/1", csrq[128 +: 32], csrq[0 +: 32]);
      end
      do_cmd(2'd2, 16'd9, 32'h0);
`ifdef USI_CSR_DROPCNT_EN
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("FAIL drop_two got %h want 2", rd);
      end
      tick();
      drive(2'd2, 8'h01, 16'd0, 32'h0);
      repeat (450) tick();
      idle_bus();
      tick();
      tick();
      tick();
      do_cmd(2'd2, 16'd9, 32'h0);
      checks++;
      if (rd !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL drop_sat got %h want ff", rd);
      end
      tick();
      drive(2'd1, 8'h01, 16'd9, 32'h0);
      tick();
      drive(2'd2, 8'h01, 16'd0, 32'h0);
      tick();
      idle_bus();
      tick();
      do_cmd(2'd2, 16'd9, 32'h0);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL drop_clr got %h want 0", rd);
      end
`else
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL nodrop_rd got %h want 0", rd);
      end
      we0 = we_seen;
      do_cmd(2'd1, 16'd9, 32'hFFFF_FFFF);
      do_cmd(2'd2, 16'd9, 32'h0);
      checks++;
      if (rd !== 32'h0 || we_seen != we0) begin
         errors++;
         $display("FAIL nodrop_wr rd=%h pulses=%0d want 0/%0d", rd, we_seen, we0);
      end
`endif
   endtask

   task automatic test_abort();
      int we0;
      we0 = we_seen;
      tick();
      drive(2'd1, 8'h01, 16'd0, 32'h1234_ABCD);
      tick();
      idle_bus();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (csrwe !== 8'h00 || vd !== 1'b1) begin
         errors++;
         $display("FAIL abort_wr we=%b vd=%b want 0/1", csrwe, vd);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (csrq[0 +: 32] !== 32'h0 || vd !== 1'b1) begin
         errors++;
         $display("FAIL abort_csr0 got %h vd=%b want 0/1", csrq[0 +: 32], vd);
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (we_seen != we0 || vd !== 1'b1 || csrq[0 +: 32] !== 32'h0) begin
         errors++;
         $display("FAIL abort_after pulses=%0d want %0d vd=%b csr0=%h",
                  we_seen, we0, vd, csrq[0 +: 32]);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_status();
      test_mismatch();
      test_back_to_back();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usi_slave_csr.md
USI_SLAVE_CSR -- requirements
Module: usi_slave_csr

Interface
REQ-001 SHALL have parameter pBusAdrs, default 8'h01, the bus address this slave answers to (compared with iSUsiAdrs[23:16]).
REQ-002 SHALL have parameter pCsrNum, default 8, the number of R/W CSRs (1..16).
REQ-003 SHALL have parameter pCsrInit, default 32'h0000_0000, the reset value of every R/W CSR.
REQ-004 SHALL have port iUsiClk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port iUsiRst, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have port iSUsiWd, input, 32, the write data from the bus.
REQ-007 SHALL have port iSUsiAdrs, input, 32, where [31:30] is the command (0 none, 1 write, 2 read, 3 reserved), [23:16] the bus address and [15:0] the CSR index.
REQ-008 SHALL have port iSUsiWCke, input, 1, which marks the command as valid.
REQ-009 SHALL have port oSUsiRd, output, 32, the read data returned to the bus.
REQ-010 SHALL have port oSUsiVd, output, 1, high when the slave can accept a command.
REQ-011 SHALL have port oCsrQ, output, 32*pCsrNum, the flattened R/W CSR contents, with CSR n at bits [32n+31:32n].
REQ-012 SHALL have port oCsrWe, output, pCsrNum, a one-cycle pulse per CSR when that CSR is written.
REQ-013 SHALL have port iCsrStatus, input, 32, a read-only status word.

Function
REQ-014 SHALL accept a command only when all of these hold: state IDLE, iSUsiWCke=1, iSUsiAdrs[23:16]=pBusAdrs, and command 1 or 2.
REQ-015 SHALL ignore command 0, command 3 and any bus-address mismatch, with no state change and no drop count.
REQ-016 SHALL use the FSM IDLE -> WR (write accepted) or RD (read accepted) -> DONE -> IDLE, spending one cycle in each of WR, RD and DONE.
REQ-017 SHALL drive oSUsiVd=1 only in IDLE, giving 3 busy cycles per accepted command.
REQ-018 SHALL, in WR with index < pCsrNum, load the CSR with the captured data and pulse the matching oCsrWe bit for exactly that cycle.
REQ-019 SHALL, in RD, register the read data into oSUsiRd, visible in the DONE cycle.
REQ-020 SHALL return the R/W CSR for index < pCsrNum, iCsrStatus (sampled in RD) for index = pCsrNum, the drop counter zero-extended for index = pCsrNum+1, and 32'h0 for any other index.
REQ-021 SHALL hold oSUsiRd unchanged until the next RD state.
REQ-022 SHALL ignore writes to index pCsrNum (status) and to out-of-range indices, with no oCsrWe pulse.
REQ-023 SHALL treat a command with iSUsiWCke=1 and matching bus address, arriving while not in IDLE, as dropped, without queuing it.
REQ-024 SHALL count each dropped command in an 8-bit drop counter that saturates at 8'hFF.
REQ-025 SHALL clear the drop counter when index pCsrNum+1 is written (any data).
REQ-026 SHALL give the clear priority when a clear and a drop occur in the same cycle, so the counter reads 0.
REQ-027 SHALL capture iSUsiWd and iSUsiAdrs at acceptance, so later changes on those inputs have no effect on the command.

Reset
REQ-028 SHALL, while iUsiRst=1, force the following: state IDLE, oSUsiVd=1, oSUsiRd=32'h0, every CSR=pCsrInit, oCsrWe=0, and drop counter=0.
REQ-029 SHALL, on reset asserted during WR, RD or DONE, abort the command with no CSR update and no oCsrWe pulse that cycle.

Configuration
REQ-030 SHALL, with USI_CSR_DROPCNT_EN defined, implement the drop counter as specified above.
REQ-031 SHALL, without USI_CSR_DROPCNT_EN, omit the drop counter, read index pCsrNum+1 as 32'h0, ignore writes to it, and still silently discard commands that arrive while busy.

Verification
REQ-032 SHALL cover: reset -> oCsrQ all 32'h0, oSUsiVd=1, oSUsiRd=0; then write cmd 1, adrs 8'h01, idx 3, data 32'hA5A5_0003 -> oCsrWe=8'b0000_1000 one cycle later for one cycle, CSR3=32'hA5A5_0003, oSUsiVd low 3 cycles.
REQ-033 SHALL cover: read idx 3 after the REQ-032 write -> oSUsiRd=32'hA5A5_0003 in the DONE cycle, held through 10 idle cycles.
REQ-034 SHALL cover: read idx 8 with iCsrStatus=32'hDEAD_BEEF -> 32'hDEAD_BEEF; read idx 12 -> 32'h0; write idx 8 -> no oCsrWe, no CSR change.
REQ-035 SHALL cover: with USI_CSR_DROPCNT_EN, write then 2 back-to-back valid commands while busy -> read idx 9 returns 2; then 300 drops -> 8'hFF; then write idx 9 -> 0.
REQ-036 SHALL cover: cmd with bus address 8'h02, or cmd 3 -> no oSUsiVd drop, no count, no CSR change.
REQ-037 SHALL cover: reset asserted in the WR cycle of a write to idx 0 -> CSR0 stays pCsrInit, oCsrWe never pulses, state IDLE afterwards.
